sprite_renderer: RTL and testbench

SPRITE_RENDERER -- requirements
Module: sprite_renderer

---
 rtl/sprite_renderer_pkg.sv | 12 +
 rtl/sprite_renderer_grid_scaler.sv | 27 ++
 rtl/sprite_renderer.sv | 120 ++++++++++++
 tb/tb_sprite_renderer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_renderer_pkg.sv
// Shared definitions for the sprite pipeline and the movement controller:
// game-field and display dimensions plus the 4:4:4 colour type.
package sprite_renderer_pkg;

  localparam int SCREEN_W = 128;  // game grid columns
  localparam int SCREEN_H = 96;   // game grid rows
  localparam int DISP_W   = 640;  // display columns
  localparam int DISP_H   = 480;  // display rows

  typedef logic [11:0] color_t;   // {r[3:0], g[3:0], b[3:0]}

endpackage

// File: rtl/sprite_renderer_grid_scaler.sv
// Maps a display pixel coordinate onto the game grid by constant division,
// flagging coordinates that fall outside the 128x96 field.
module grid_scaler
  import sprite_renderer_pkg::*;
#(
  parameter int SCALE = 5
) (
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  output logic [6:0] gx,
  output logic [6:0] gy,
  output logic       oof
);

  logic [9:0] qx;
  logic [9:0] qy;

  // Full-width quotients are kept so the field check sees the untruncated cell.
  always_comb begin
    qx  = pixel_x / 10'(SCALE);
    qy  = pixel_y / 10'(SCALE);
    gx  = qx[6:0];
    gy  = qy[6:0];
    oof = (qx >= 10'(SCREEN_W)) || (qy >= 10'(SCREEN_H));
  end

endmodule

// File: rtl/sprite_renderer.sv
// Two-stage pixel pipeline that paints a rectangular sprite on the game grid,
// plus a frame divider that paces the movement controller.
module sprite_renderer
  import sprite_renderer_pkg::*;
#(
  parameter int     SCALE    = 5,
  parameter int     MOVE_DIV = 4,
  parameter color_t FG_COLOR = 12'hFFF,
  parameter color_t BG_COLOR = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        pixel_valid,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic [6:0]  xPos,
  input  logic [6:0]  yPos,
  input  logic [6:0]  WIDTH,
  input  logic [6:0]  HEIGHT,
  output logic        move_en,
  output logic        hit,
  output logic        rgb_valid,
  output logic [11:0] rgb
);

  logic [6:0] sx_q, sy_q, sw_q, sh_q;
  logic [6:0] sx_d, sy_d, sw_d, sh_d;
  logic [3:0] frame_cnt_q, frame_cnt_d;
  logic       move_en_q, move_en_d;
  logic       v1_q, v1_d, hit1_q, hit1_d;
  logic       v2_q, v2_d, hit2_q, hit2_d;
  color_t     rgb_q, rgb_d;

  logic [6:0] gx, gy;
  logic       oof;
  logic [7:0] gx_e, gy_e, end_x, end_y;
  logic       in_x, in_y;

  grid_scaler #(.SCALE(SCALE)) u_scaler (
    .pixel_x (pixel_x),
    .pixel_y (pixel_y),
    .gx      (gx),
    .gy      (gy),
    .oof     (oof)
  );

  // Shadow capture and frame divider; the wrap cycle requests a move pulse next cycle.
  always_comb begin
    sx_d        = sx_q;
    sy_d        = sy_q;
    sw_d        = sw_q;
    sh_d        = sh_q;
    frame_cnt_d = frame_cnt_q;
    move_en_d   = 1'b0;
    if (frame_start) begin
      sx_d = xPos;
      sy_d = yPos;
      sw_d = WIDTH;
      sh_d = HEIGHT;
      if (frame_cnt_q == 4'(MOVE_DIV - 1)) begin
        frame_cnt_d = 4'd0;
        move_en_d   = 1'b1;
      end else begin
        frame_cnt_d = frame_cnt_q + 4'd1;
      end
    end
  end

  // Hit test against the current shadow (pre-capture on a frame_start cycle);
  // sums are 8 bits wide so a sprite near the edge never wraps to column 0.
  always_comb begin
    gx_e   = {1'b0, gx};
    gy_e   = {1'b0, gy};
    end_x  = {1'b0, sx_q} + {1'b0, sw_q};
    end_y  = {1'b0, sy_q} + {1'b0, sh_q};
    in_x   = (gx_e >= {1'b0, sx_q}) && (gx_e < end_x);
    in_y   = (gy_e >= {1'b0, sy_q}) && (gy_e < end_y);
    v1_d   = pixel_valid;
    hit1_d = pixel_valid && !oof && in_x && in_y;
    v2_d   = v1_q;
    hit2_d = v1_q && hit1_q;
    rgb_d  = (v1_q && hit1_q) ? FG_COLOR : BG_COLOR;
  end

  // State registers; reset discards the shadow, divider and in-flight pixels.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sx_q        <= '0;
      sy_q        <= '0;
      sw_q        <= '0;
      sh_q        <= '0;
      frame_cnt_q <= '0;
      move_en_q   <= 1'b0;
      v1_q        <= 1'b0;
      hit1_q      <= 1'b0;
      v2_q        <= 1'b0;
      hit2_q      <= 1'b0;
      rgb_q       <= BG_COLOR;
    end else begin
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      sw_q        <= sw_d;
      sh_q        <= sh_d;
      frame_cnt_q <= frame_cnt_d;
      move_en_q   <= move_en_d;
      v1_q        <= v1_d;
      hit1_q      <= hit1_d;
      v2_q        <= v2_d;
      hit2_q      <= hit2_d;
      rgb_q       <= rgb_d;
    end
  end

  assign move_en   = move_en_q;
  assign hit       = hit2_q;
  assign rgb_valid = v2_q;
  assign rgb       = rgb_q;

endmodule

// File: tb/tb_sprite_renderer.sv
// Directed bench for sprite_renderer: stimulus pushes hand-computed results
// into a scoreboard, a negedge monitor pops and compares on rgb_valid.
module tb_sprite_renderer;
  import sprite_renderer_pkg::*;

  typedef struct packed {
    logic       hit;
    logic [11:0] rgb;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic        pixel_valid;
  logic [9:0]  pixel_x, pixel_y;
  logic [6:0]  xPos, yPos, WIDTH, HEIGHT;
  logic        move_en, hit, rgb_valid;
  logic [11:0] rgb;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  logic exp_move = 1'b0;
  int   valid_seen = 0;
  int   run = 0;
  int   max_run = 0;
  bit   quiet = 1'b0;

  always #5 clk = ~clk;

  sprite_renderer dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .pixel_valid (pixel_valid),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .xPos        (xPos),
    .yPos        (yPos),
    .WIDTH       (WIDTH),
    .HEIGHT      (HEIGHT),
    .move_en     (move_en),
    .hit         (hit),
    .rgb_valid   (rgb_valid),
    .rgb         (rgb)
  );

  // Monitor: move_en every cycle, scoreboard pop on rgb_valid, idle outputs otherwise.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      checks++;
      if (move_en !== exp_move) begin
        errors++;
        $display("FAIL move_en got=%b exp=%b t=%0t", move_en, exp_move, $time);
      end
      if (rgb_valid === 1'b1) begin
        valid_seen++;
        run++;
        if (run > max_run) max_run = run;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow got rgb_valid=1 exp no pending pixel t=%0t", $time);
        end else begin
          mon_e = sb.pop_front();
          if (hit !== mon_e.hit) begin
            errors++;
            $display("FAIL hit got=%b exp=%b t=%0t", hit, mon_e.hit, $time);
          end
          checks++;
          if (rgb !== mon_e.rgb) begin
            errors++;
            $display("FAIL rgb got=%h exp=%h t=%0t", rgb, mon_e.rgb, $time);
          end
        end
      end else begin
        run = 0;
        checks++;
        if (rgb !== 12'h000 || hit !== 1'b0) begin
          errors++;
          $display("FAIL idle_out got rgb=%h hit=%b exp rgb=000 hit=0 t=%0t", rgb, hit, $time);
        end
      end
    end
  end

  // One cycle of stimulus; exp_hit<0 means the pixel is not expected to emerge.
  task automatic drive(input logic fs, input logic pv, input int px, input int py,
                       input int exp_hit, input logic exp_mv);
    exp_t e;
    frame_start = fs;
    pixel_valid = pv;
    pixel_x     = 10'(px);
    pixel_y     = 10'(py);
    if (pv && exp_hit >= 0) begin
      e.hit = (exp_hit != 0);
      e.rgb = (exp_hit != 0) ? 12'hFFF : 12'h000;
      sb.push_back(e);
    end
    if (!quiet)
      $display("drive fs=%0d pv=%0d px=%0d py=%0d sprite=(%0d,%0d,%0d,%0d) exp_hit=%0d exp_move_next=%0d",
               fs, pv, px, py, xPos, yPos, WIDTH, HEIGHT, exp_hit, exp_mv);
    @(posedge clk);
    #1;
    exp_move    = exp_mv;
    frame_start = 1'b0;
    pixel_valid = 1'b0;
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Hold reset for a few cycles, check the cleared outputs, release after a posedge.
  task automatic do_reset();
    reset    = 1'b0;
    exp_move = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rgb_valid", int'(rgb_valid), 0);
    check("rst_move_en", int'(move_en), 0);
    check("rst_rgb", int'(rgb), 0);
    check("rst_hit", int'(hit), 0);
    check("rst_sb_empty", sb.size(), 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic set_sprite(input int x, input int y, input int w, input int h);
    xPos = 7'(x); yPos = 7'(y); WIDTH = 7'(w); HEIGHT = 7'(h);
  endtask

  initial begin
    int base;
    reset = 1'b0;
    frame_start = 1'b0;
    pixel_valid = 1'b0;
    pixel_x = '0;
    pixel_y = '0;
    set_sprite(10, 20, 4, 3);

    // Reset with xPos=10 applied; no hit before the first capture.
    do_reset();
    drive(0, 1, 50, 100, 0, 0);
    drive(0, 0, 0, 0, -1, 0);

    // Nine frame pulses: move_en follows pulses 4 and 8 only.
    for (int i = 1; i <= 9; i++)
      drive(1, 0, 0, 0, -1, (i == 4 || i == 8));

    // Sprite at (10,20) size 4x3.
    drive(0, 1, 50, 100, 1, 0);
    drive(0, 1, 69, 114, 1, 0);
    drive(0, 1, 70, 100, 0, 0);
    drive(0, 1, 49, 100, 0, 0);
    drive(0, 1, 50, 115, 0, 0);

    // Right-edge clipping: xPos=126, W=5 covers gx 126,127 only.
    set_sprite(126, 0, 5, 3);
    drive(1, 0, 0, 0, -1, 0);
    drive(0, 1, 625, 0, 0, 0);
    drive(0, 1, 630, 0, 1, 0);
    drive(0, 1, 635, 7, 1, 0);
    drive(0, 1, 639, 14, 1, 0);
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 1, 4, 14, 0, 0);
    drive(0, 1, 630, 15, 0, 0);

    // Same-cycle frame_start and pixel: old shadow applies for that pixel.
    set_sprite(10, 0, 2, 2);
    drive(1, 0, 0, 0, -1, 0);
    set_sprite(40, 0, 2, 2);
    drive(1, 1, 50, 0, 1, 1);
    drive(0, 1, 50, 0, 0, 0);
    drive(0, 1, 200, 5, 1, 0);

    // Zero width: full grid scan never hits, output stream is continuous.
    set_sprite(0, 0, 0, 5);
    drive(1, 0, 0, 0, -1, 0);
    drive(0, 0, 0, 0, -1, 0);
    drive(0, 0, 0, 0, -1, 0);
    quiet   = 1'b1;
    base    = valid_seen;
    max_run = 0;
    for (int gy = 0; gy < 96; gy++)
      for (int gx = 0; gx < 128; gx++)
        drive(0, 1, gx * 5, gy * 5, 0, 0);
    drive(0, 0, 0, 0, -1, 0);
    drive(0, 0, 0, 0, -1, 0);
    quiet = 1'b0;
    check("scan_valid_count", valid_seen - base, 128 * 96);
    check("scan_continuous", max_run, 128 * 96);

    // Reset with a pixel in flight: it is dropped, divider restarts.
    set_sprite(0, 0, 4, 4);
    drive(1, 0, 0, 0, -1, 0);
    drive(0, 1, 0, 0, -1, 0);
    do_reset();
    drive(0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++)
      drive(1, 0, 0, 0, -1, (i == 4));
    drive(0, 1, 5, 5, 1, 0);
    repeat (3) drive(0, 0, 0, 0, -1, 0);
    check("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
